// File: rtl/delay_scheduler.sv
// rtl/delay_scheduler.sv - one delay counter shared round-robin among NUM_REQ requesters
//
// Purpose: each requester holds req[i] high with its wait length on
// req_cycles[i*CNT_W +: CNT_W]; the arbiter grants the single counter to one
// requester at a time, times target+1 cycles from grant and returns a
// one-cycle done pulse to that requester.
//
// Ports:
//   clock      - system clock, rising edge
//   resetn     - asynchronous active-low reset, synchronous release
//   req        - per-requester level request, held until its done pulse
//   req_cycles - flat bus of delay targets, CNT_W bits per requester
//   grant      - registered one-hot (or zero) owner of the counter
//   done       - registered one-cycle completion pulse to the owner
//   busy       - high while the scheduler is not idle
//   cur_count  - live counter value for debug
module delay_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 18
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_cycles,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         cur_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic [CNT_W-1:0]   counter, counter_n;
  logic [CNT_W-1:0]   target, target_n;
  // rr_ptr doubles as the index of the current owner while counting.
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;

  logic [CNT_W-1:0]   cycles_arr [NUM_REQ];
  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W:0]     cand;
  logic [NUM_REQ-1:0] win_onehot;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      cycles_arr[k] = req_cycles[k*CNT_W +: CNT_W];
    end
  end

  // Search rr_ptr+1, rr_ptr+2, ... with wrap; the previous owner is checked last.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      grant   <= '0;
      done    <= '0;
      counter <= '0;
      target  <= '0;
      rr_ptr  <= LAST_IDX;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      done    <= done_n;
      counter <= counter_n;
      target  <= target_n;
      rr_ptr  <= rr_ptr_n;
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    done_n    = '0;
    counter_n = counter;
    target_n  = target;
    rr_ptr_n  = rr_ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n   = win_onehot;
          target_n  = cycles_arr[win];
          counter_n = '0;
          rr_ptr_n  = win;
          state_n   = COUNT;
        end
      end
      COUNT: begin
        if (!req[rr_ptr]) begin
          // Owner withdrew: release the counter silently.
          state_n   = IDLE;
          grant_n   = '0;
          counter_n = '0;
        end else if (counter == target) begin
          state_n = DONE;
          done_n  = grant;
        end else begin
          counter_n = counter + 1'b1;
        end
      end
      DONE: begin
        grant_n   = '0;
        counter_n = '0;
        state_n   = IDLE;
      end
      default: begin
        grant_n   = '0;
        counter_n = '0;
        state_n   = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign cur_count = counter;

endmodule

// File: tb/tb_delay_scheduler.sv
// tb/tb_delay_scheduler.sv - directed self-checking bench for delay_scheduler
module tb_delay_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 18;

  logic                     clock = 1'b0;
  logic                     resetn;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] req_cycles;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [CNT_W-1:0]         cur_count;

  int tests  = 0;
  int failed = 0;
  int n;
  logic [NUM_REQ-1:0] exp_oh;

  delay_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req        (req),
    .req_cycles (req_cycles),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .cur_count  (cur_count)
  );

  always #5 clock = ~clock;

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_cycles(input int idx, input logic [CNT_W-1:0] val);
    req_cycles[idx*CNT_W +: CNT_W] = val;
  endtask

  task automatic wait_done(input int budget);
    n = 0;
    while (done == '0 && n < budget) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    req        = '0;
    req_cycles = '0;
    step(3);
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(cur_count), 0);
    resetn = 1'b1;
    step(2);
    check("idle_busy", 32'(busy), 0);

    // Round-robin with all four held: 0,1,2,3,0 then 1
    for (int k = 0; k < NUM_REQ; k++) set_cycles(k, 5);
    req = 4'b1111;
    step(1);
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      check($sformatf("rr_grant_%0d", k), 32'(grant), 32'(exp_oh));
      step(5);
      check($sformatf("rr_early_%0d", k), 32'(done), 0);
      step(1);
      check($sformatf("rr_done_%0d", k), 32'(done), 32'(exp_oh));
      step(1);
      check($sformatf("rr_gap_%0d", k), 32'(grant | done), 0);
      step(1);
    end
    check("rr_grant_5", 32'(grant), 32'(4'b0010));
    req = '0;
    step(1);
    check("rr_abort_grant", 32'(grant), 0);
    step(2);

    // Abort: requester 1 drops at count 40, pending requester 3 wins next
    set_cycles(1, 100);
    req = 4'b0010;
    step(1);
    check("ab_grant1", 32'(grant), 32'(4'b0010));
    req = 4'b1010;
    step(40);
    check("ab_count40", 32'(cur_count), 40);
    req = 4'b1000;
    step(1);
    check("ab_grant0", 32'(grant), 0);
    check("ab_nodone", 32'(done), 0);
    check("ab_busy", 32'(busy), 0);
    check("ab_count0", 32'(cur_count), 0);
    step(1);
    check("ab_grant3", 32'(grant), 32'(4'b1000));
    req = '0;
    step(3);

    // Single requester, long wait
    set_cycles(0, 1000);
    req = 4'b0001;
    step(1);
    check("s_grant", 32'(grant), 32'(4'b0001));
    check("s_busy", 32'(busy), 1);
    check("s_count0", 32'(cur_count), 0);
    wait_done(2000);
    check("s_latency", 32'(n), 1001);
    check("s_done", 32'(done), 32'(4'b0001));
    check("s_count_max", 32'(cur_count), 1000);
    check("s_busy_at_done", 32'(busy), 1);
    req = '0;
    step(1);
    check("s_done_width", 32'(done), 0);
    check("s_busy_fall", 32'(busy), 0);
    step(2);

    // Target zero
    set_cycles(2, 0);
    req = 4'b0100;
    step(1);
    check("z_grant", 32'(grant), 32'(4'b0100));
    step(1);
    check("z_done", 32'(done), 32'(4'b0100));
    req = '0;
    step(1);
    check("z_done_width", 32'(done), 0);
    step(2);

    // Late target change is ignored
    set_cycles(0, 10);
    req = 4'b0001;
    step(1);
    check("lt_grant", 32'(grant), 32'(4'b0001));
    n = 0;
    while (done == '0 && n < 100) begin
      if (n == 4) set_cycles(0, 3);
      step(1);
      n++;
    end
    check("lt_latency", 32'(n), 11);
    req = '0;
    step(3);

    // Async reset mid-count, then priority restored to requester 0
    set_cycles(0, 100);
    req = 4'b0001;
    step(1);
    step(50);
    check("ar_count50", 32'(cur_count), 50);
    #2 resetn = 1'b0;
    #1;
    check("ar_grant", 32'(grant), 0);
    check("ar_done", 32'(done), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_count", 32'(cur_count), 0);
    req = 4'b1111;
    step(1);
    resetn = 1'b1;
    step(1);
    check("ar_first_grant", 32'(grant), 32'(4'b0001));
    check("ar_no_done", 32'(done), 0);
    req = '0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/delay_scheduler.md
Name: delay_scheduler

Overview:
- Shares one programmable delay counter among NUM_REQ requesters, for example motor-settle, camera-capture and servo-step sequencers in the object-detection datapath.
- Each requester asks for a wait of its own length in clock cycles.
- A round-robin arbiter grants the counter to one requester at a time, times the wait, then returns a one-cycle done pulse to that requester.
- This replaces per-sequencer delay counters with a single 100 MHz timer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 18, counter and target width. 200000 cycles (2 ms at 100 MHz) fits.

Ports:
- clock, input, 1, 100 MHz system clock. All logic is on the rising edge.
- resetn, input, 1, asynchronous active-low reset.
- req, input, NUM_REQ, per-requester level request. Held high until that requester's done pulse.
- req_cycles, input, NUM_REQ*CNT_W, flat bus of delay targets. Requester i uses bits [i*CNT_W +: CNT_W].
- grant, output, NUM_REQ, one-hot (or zero) owner of the counter. Registered.
- done, output, NUM_REQ, one-cycle pulse to the owner when its delay completes. Registered.
- busy, output, 1, high while state is not IDLE.
- cur_count, output, CNT_W, live counter value, for debug.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant=0, done=0, busy=0.
  - counter=0, target=0, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If req is nonzero, pick the first set bit searching rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_REQ.
  - On that edge: grant becomes one-hot for the winner g; target is latched from req_cycles[g]; counter=0; rr_ptr=g; state=COUNT.
  - If req is zero, remain in IDLE.
- COUNT, evaluated in priority order:
  - (a) req[g]=0 means abort. Go to IDLE with grant=0, no done pulse, counter=0. rr_ptr stays g.
  - (b) counter==target: state=DONE, done[g]=1, grant is held.
  - (c) Otherwise counter increments by 1.
- DONE:
  - done=0, grant=0, counter=0, state=IDLE.
  - done is therefore high for exactly one cycle.
- Latency:
  - done rises target+1 cycles after grant rises.
  - target=0 gives done one cycle after grant.
- Requester rule: deassert req in the cycle done is high. The IDLE cycle after DONE samples req. A req still high is treated as a new request.
- Minimum spacing from one done pulse to the next grant is 2 cycles (DONE→IDLE, IDLE→COUNT).
- Changes on req_cycles after grant are ignored, because target is latched.
- New requests from other requesters during COUNT wait; nothing is queued beyond the req level.
- Invariants:
  - Counter never exceeds target.
  - No wrap past 2^CNT_W-1 is possible, since target ≤ 2^CNT_W-1.
  - grant and done are never multi-hot.
- busy=1 in COUNT and DONE.
- cur_count=counter.
- resetn asserted mid-COUNT: all outputs clear immediately (asynchronously). No done pulse follows.

Test Plan:
- Single requester: req[0]=1, req_cycles[0]=200000 → grant=0001 next edge; done[0] pulses exactly 200001 cycles after grant; busy falls one cycle after done.
- Target zero: req[2]=1, cycles=0 → grant=0100, then done[2] one cycle later, one cycle wide.
- Round-robin fairness: req=1111 held (each requester re-requests after its done), all cycles=5 → grant order 0,1,2,3,0; each done 6 cycles after its grant; 2-cycle gap between done and next grant.
- Abort: req[1]=1, cycles=100; drop req[1] at count 40 → state returns to IDLE, no done pulse; pending req[3] is granted 1 cycle later.
- Late target change: change req_cycles[0] from 10 to 3 mid-count → done still at 11 cycles after grant.
- Async reset: assert resetn=0 at count 50 → grant, done, busy and cur_count go to 0 without a clock edge; after release, req[0] is granted first.
